mem_stage: RTL and testbench

- MEM pipeline stage. Sits directly downstream of the EX/MEM register and upstream of the MEM/WB writeback path.
- Consumes the registered mem_params_t and the data-memory response. Completes loads and stores, stalling the pipeline while a data-memory access is outstanding.
- Produces a registered writeback bundle (wb_params_t) and a forwarding tap for EX.

---
 rtl/mem_stage_pkg.sv | 38 +++
 rtl/mem_stage_if.sv | 32 +++
 rtl/mem_stage.sv | 95 +++++++++
 tb/tb_mem_stage.sv | 169 ++++++++++++++++
 4 files changed

// File: rtl/mem_stage_pkg.sv
// mem_stage_pkg
// Shared types for the MEM pipeline stage:
//   u32_t        - 32-bit data word
//   mem_op_t     - memory operation code carried by EX/MEM
//   mem_params_t - EX/MEM register contents consumed by mem_stage
//   wb_params_t  - MEM/WB bundle produced by mem_stage
//   mem_state_t  - mem_stage access state (idle / waiting on data memory)
package mem_stage_pkg;

    typedef logic [31:0] u32_t;

    typedef enum logic [1:0] {
        MEM_OP_NONE  = 2'd0,
        MEM_OP_LOAD  = 2'd1,
        MEM_OP_STORE = 2'd2
    } mem_op_t;

    typedef struct packed {
        logic [4:0] rd_addr;
        u32_t       rd_data;   // ALU result, or the address for memory ops
        mem_op_t    mem_op;
        u32_t       mem_data;  // store data (consumed by the dmem request upstream)
    } mem_params_t;

    typedef struct packed {
        logic [4:0] rd_addr;
        u32_t       rd_data;
        logic       wr_en;
    } wb_params_t;

    typedef enum logic {
        MEM_ST_IDLE,
        MEM_ST_WAIT
    } mem_state_t;

    localparam wb_params_t WB_BUBBLE = '0;

endpackage

// File: rtl/mem_stage_if.sv
// mem_stage_if
// Bundles the MEM stage datapath/handshake signals.
//   mem_params_in - EX/MEM register contents
//   dmem_rddata   - data-memory read data (valid with dmem_ack)
//   dmem_ack      - data-memory completion for the presented request
//   stall         - hold request for IF..EX/MEM
//   wb_params_out - registered writeback bundle
//   fwd_addr/data - forwarding tap towards EX
//   bus_err       - one-cycle pulse on an aborted access
// Modports: slave = the MEM stage itself, master = its environment.
interface mem_stage_if;
    import mem_stage_pkg::*;

    mem_params_t mem_params_in;
    u32_t        dmem_rddata;
    logic        dmem_ack;
    logic        stall;
    wb_params_t  wb_params_out;
    logic [4:0]  fwd_addr;
    u32_t        fwd_data;
    logic        bus_err;

    modport slave (
        input  mem_params_in, dmem_rddata, dmem_ack,
        output stall, wb_params_out, fwd_addr, fwd_data, bus_err
    );

    modport master (
        output mem_params_in, dmem_rddata, dmem_ack,
        input  stall, wb_params_out, fwd_addr, fwd_data, bus_err
    );
endinterface

// File: rtl/mem_stage.sv
// mem_stage
// MEM pipeline stage: completes loads/stores against the data memory,
// stalls upstream while an access is outstanding and produces the
// registered writeback bundle plus a combinational forwarding tap.
// Ports:
//   clk   - clock, all state on posedge
//   rst_n - asynchronous active-low reset
//   bus   - mem_stage_if.slave (see interface header for signal list)
// Optional feature: define MINA_MEM_TIMEOUT_EN to abort an access that has
// waited TIMEOUT_CYCLES cycles without dmem_ack (bus_err pulses for one
// cycle). Without it, a wait lasts until dmem_ack and bus_err is held 0.
module mem_stage
    import mem_stage_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 16,
    parameter int CNT_W          = $clog2(TIMEOUT_CYCLES + 1)
) (
    input  logic        clk,
    input  logic        rst_n,
    mem_stage_if.slave  bus
);

    mem_state_t state_reg;
    wb_params_t wb_reg;
    logic       bus_err_reg;

    wb_params_t wb_next;
    logic       is_mem_op;
    logic       timeout;
    logic       stall_int;

    // Next writeback value; anything that does not complete this cycle
    // (store, no ack, abort) becomes a bubble.
    always_comb begin
        wb_next   = WB_BUBBLE;
        is_mem_op = (bus.mem_params_in.mem_op != MEM_OP_NONE);
        if (!is_mem_op) begin
            wb_next.rd_addr = bus.mem_params_in.rd_addr;
            wb_next.rd_data = bus.mem_params_in.rd_data;
            wb_next.wr_en   = (bus.mem_params_in.rd_addr != 5'd0);
        end else if (bus.dmem_ack && bus.mem_params_in.mem_op == MEM_OP_LOAD) begin
            wb_next.rd_addr = bus.mem_params_in.rd_addr;
            wb_next.rd_data = bus.dmem_rddata;
            wb_next.wr_en   = (bus.mem_params_in.rd_addr != 5'd0);
        end
    end

`ifdef MINA_MEM_TIMEOUT_EN
    localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;

    logic [CNT_W-1:0] cnt_reg;

    assign timeout = (state_reg == MEM_ST_WAIT) && (cnt_reg >= CNT_LIMIT)
                     && is_mem_op && !bus.dmem_ack;

    // Counts stalled cycles of the current access; the IDLE->WAIT edge
    // already counts as one, so the abort lands on cycle TIMEOUT_CYCLES+1.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_reg <= '0;
        end else if (stall_int) begin
            if (cnt_reg != CNT_MAX) begin
                cnt_reg <= cnt_reg + 1'b1;
            end
        end else begin
            cnt_reg <= '0;
        end
    end
`else
    assign timeout = 1'b0;
`endif

    assign stall_int = is_mem_op && !bus.dmem_ack && !timeout;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg   <= MEM_ST_IDLE;
            wb_reg      <= WB_BUBBLE;
            bus_err_reg <= 1'b0;
        end else begin
            wb_reg      <= wb_next;
            bus_err_reg <= timeout;
            state_reg   <= stall_int ? MEM_ST_WAIT : MEM_ST_IDLE;
        end
    end

    assign bus.stall         = stall_int;
    assign bus.wb_params_out = wb_reg;
    assign bus.bus_err       = bus_err_reg;
    // wb_next already has wr_en=0 for non-writing cases; the tap must read 0 then.
    assign bus.fwd_addr      = wb_next.wr_en ? wb_next.rd_addr : 5'd0;
    assign bus.fwd_data      = wb_next.wr_en ? wb_next.rd_data : 32'd0;

endmodule

// File: tb/tb_mem_stage.sv
module tb_mem_stage;
    import mem_stage_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    mem_stage_if bus();

    mem_stage #(.TIMEOUT_CYCLES(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int errors = 0;
    int checks = 0;

    typedef struct {
        wb_params_t wb;
        logic       berr;
    } exp_t;
    exp_t sb_q[$];

    typedef struct {
        mem_op_t    op;
        logic [4:0] rd;
        u32_t       data;
        logic       ack;
        u32_t       rddata;
        logic       exp_stall;
        wb_params_t exp_wb;
    } vec_t;
    vec_t vecs[7];

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    function automatic wb_params_t mk_wb(input logic [4:0] a, input u32_t d, input logic w);
        wb_params_t r;
        r.rd_addr = a;
        r.rd_data = d;
        r.wr_en   = w;
        return r;
    endfunction

    // One clock cycle: drive at negedge, check the combinational outputs,
    // push the expected registered result, pop and compare after the edge.
    task automatic run_cycle(input string tag, input mem_op_t op, input logic [4:0] rd,
                             input u32_t data, input logic ack, input u32_t rddata,
                             input logic exp_stall, input wb_params_t exp_wb, input logic exp_berr);
        exp_t e;
        exp_t got;
        @(negedge clk);
        bus.mem_params_in.mem_op   = op;
        bus.mem_params_in.rd_addr  = rd;
        bus.mem_params_in.rd_data  = data;
        bus.mem_params_in.mem_data = 32'hC0FFEE00;
        bus.dmem_ack    = ack;
        bus.dmem_rddata = rddata;
        #1;
        chk({tag, " stall"}, 64'(bus.stall), 64'(exp_stall));
        chk({tag, " fwd_addr"}, 64'(bus.fwd_addr), 64'(exp_wb.wr_en ? exp_wb.rd_addr : 5'd0));
        chk({tag, " fwd_data"}, 64'(bus.fwd_data), 64'(exp_wb.wr_en ? exp_wb.rd_data : 32'd0));
        e.wb = exp_wb;
        e.berr = exp_berr;
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        got = sb_q.pop_front();
        chk({tag, " wb"}, 64'(bus.wb_params_out), 64'(got.wb));
        chk({tag, " bus_err"}, 64'(bus.bus_err), 64'(got.berr));
        $display("cycle %s op=%0d rd=%0d ack=%0b stall=%0b wb={%0d,%h,%0b} bus_err=%0b",
                 tag, op, rd, ack, bus.stall, bus.wb_params_out.rd_addr,
                 bus.wb_params_out.rd_data, bus.wb_params_out.wr_en, bus.bus_err);
    endtask

    initial begin
        bus.mem_params_in = '0;
        bus.dmem_ack      = 1'b0;
        bus.dmem_rddata   = '0;

        vecs[0] = '{MEM_OP_NONE,  5'd3, 32'h00001234, 1'b0, 32'h0,        1'b0, mk_wb(5'd3, 32'h00001234, 1'b1)};
        vecs[1] = '{MEM_OP_NONE,  5'd0, 32'h0000ABCD, 1'b0, 32'h0,        1'b0, mk_wb(5'd0, 32'h0000ABCD, 1'b0)};
        vecs[2] = '{MEM_OP_LOAD,  5'd5, 32'h00000100, 1'b1, 32'hDEADBEEF, 1'b0, mk_wb(5'd5, 32'hDEADBEEF, 1'b1)};
        vecs[3] = '{MEM_OP_NONE,  5'd4, 32'h00001111, 1'b1, 32'h99999999, 1'b0, mk_wb(5'd4, 32'h00001111, 1'b1)};
        vecs[4] = '{MEM_OP_STORE, 5'd6, 32'h00002222, 1'b1, 32'h12345678, 1'b0, WB_BUBBLE};
        vecs[5] = '{MEM_OP_LOAD,  5'd0, 32'h00000200, 1'b1, 32'h00000077, 1'b0, mk_wb(5'd0, 32'h00000077, 1'b0)};
        vecs[6] = '{MEM_OP_NONE,  5'd31, 32'hFFFFFFFF, 1'b0, 32'h0,       1'b0, mk_wb(5'd31, 32'hFFFFFFFF, 1'b1)};

        // Reset state
        #12;
        chk("reset wb", 64'(bus.wb_params_out), 64'(WB_BUBBLE));
        chk("reset bus_err", 64'(bus.bus_err), 64'd0);
        rst_n = 1'b1;

        // Single-cycle table
        for (int i = 0; i < 7; i++) begin
            run_cycle($sformatf("vec%0d", i), vecs[i].op, vecs[i].rd, vecs[i].data, vecs[i].ack,
                      vecs[i].rddata, vecs[i].exp_stall, vecs[i].exp_wb, 1'b0);
        end

        // Waited store: 3 stalled cycles then ack
        for (int i = 0; i < 3; i++) begin
            run_cycle($sformatf("st_wait%0d", i), MEM_OP_STORE, 5'd9, 32'h300, 1'b0, 32'h0,
                      1'b1, WB_BUBBLE, 1'b0);
        end
        run_cycle("st_ack", MEM_OP_STORE, 5'd9, 32'h300, 1'b1, 32'hAAAA0000, 1'b0, WB_BUBBLE, 1'b0);

        // Waited load: 2 stalled cycles, ack with data, then pass-through
        for (int i = 0; i < 2; i++) begin
            run_cycle($sformatf("ld_wait%0d", i), MEM_OP_LOAD, 5'd8, 32'h400, 1'b0, 32'h0,
                      1'b1, WB_BUBBLE, 1'b0);
        end
        run_cycle("ld_ack", MEM_OP_LOAD, 5'd8, 32'h400, 1'b1, 32'h55AA55AA,
                  1'b0, mk_wb(5'd8, 32'h55AA55AA, 1'b1), 1'b0);
        run_cycle("after_ld", MEM_OP_NONE, 5'd7, 32'h00007777, 1'b0, 32'h0,
                  1'b0, mk_wb(5'd7, 32'h00007777, 1'b1), 1'b0);

        // Async reset clears a non-zero wb immediately
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst wb", 64'(bus.wb_params_out), 64'(WB_BUBBLE));
        @(negedge clk);
        rst_n = 1'b1;

        // Reset mid-WAIT with a LOAD pending
        run_cycle("rst_ld_wait", MEM_OP_LOAD, 5'd12, 32'h500, 1'b0, 32'h0, 1'b1, WB_BUBBLE, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_wait wb", 64'(bus.wb_params_out), 64'(WB_BUBBLE));
        chk("rst_wait bus_err", 64'(bus.bus_err), 64'd0);
        chk("rst_wait stall", 64'(bus.stall), 64'd1);
        @(negedge clk);
        rst_n = 1'b1;
        run_cycle("post_rst", MEM_OP_NONE, 5'd2, 32'h0000BEEF, 1'b0, 32'h0,
                  1'b0, mk_wb(5'd2, 32'h0000BEEF, 1'b1), 1'b0);

`ifdef MINA_MEM_TIMEOUT_EN
        // Timeout with TIMEOUT_CYCLES=4: 4 stalled cycles, abort on the 5th
        for (int i = 0; i < 4; i++) begin
            run_cycle($sformatf("to_wait%0d", i), MEM_OP_LOAD, 5'd10, 32'h600, 1'b0, 32'h0,
                      1'b1, WB_BUBBLE, 1'b0);
        end
        run_cycle("to_abort", MEM_OP_LOAD, 5'd10, 32'h600, 1'b0, 32'h0, 1'b0, WB_BUBBLE, 1'b1);
        run_cycle("to_late_ack", MEM_OP_NONE, 5'd0, 32'h0000F00D, 1'b1, 32'h11111111,
                  1'b0, mk_wb(5'd0, 32'h0000F00D, 1'b0), 1'b0);
`else
        // Without the timeout the wait is held indefinitely
        for (int i = 0; i < 6; i++) begin
            run_cycle($sformatf("hold_wait%0d", i), MEM_OP_LOAD, 5'd10, 32'h600, 1'b0, 32'h0,
                      1'b1, WB_BUBBLE, 1'b0);
        end
        run_cycle("hold_ack", MEM_OP_LOAD, 5'd10, 32'h600, 1'b1, 32'h0BADF00D,
                  1'b0, mk_wb(5'd10, 32'h0BADF00D, 1'b1), 1'b0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
